// File: rtl/phy_rx_pattern_gen.sv
// Serial framed-traffic source for the phy_rx receiver.
// Each frame is NUM_COMMA comma bytes followed by PAYLOAD_BYTES generated
// payload bytes, shifted out MSB first on every enabled lane, one bit per clk32.
// The state register names the phase that owns the next edge. The edge that
// samples start therefore already shows COMMA[7], and the FIN edge shows the
// idle/done values, so a held start yields exactly one zero cycle between frames.
module phy_rx_pattern_gen #(
  parameter int         LANES         = 2,
  parameter logic [7:0] COMMA         = 8'hBC,
  parameter int         NUM_COMMA     = 4,
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         CNT_W         = 8
) (
  input  logic             clk32,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [7:0]       seed,
  input  logic             lane_offset,
  input  logic [LANES-1:0] lane_en,
  output logic [LANES-1:0] serial_o,
  output logic             busy,
  output logic             done,
  output logic             in_sync
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, FIN} state_t;

  localparam logic [CNT_W-1:0] LAST_COMMA = CNT_W'(NUM_COMMA - 1);
  localparam logic [CNT_W-1:0] LAST_PAY   = CNT_W'(PAYLOAD_BYTES - 1);

  state_t           state;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       gen_byte;
  logic [7:0]       gen_next;
  logic [1:0]       mode_l;
  logic             offset_l;
  logic [LANES-1:0] en_l;

  // Next payload byte for the latched generator mode.
  function automatic logic [7:0] next_byte(input logic [1:0] m, input logic [7:0] cur);
    logic [7:0] nb;
    case (m)
      2'b01:   nb = cur + 8'd1;
      2'b10:   nb = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
      default: nb = cur;
    endcase
    return nb;
  endfunction

  // Payload bit b for every lane; lanes may add their own index to the byte.
  function automatic logic [LANES-1:0] lane_bits(input logic [7:0] g, input logic [2:0] b,
                                                 input logic off, input logic [LANES-1:0] en);
    logic [LANES-1:0] bits;
    logic [7:0]       lb;
    for (int i = 0; i < LANES; i++) begin
      lb      = g + (off ? 8'(i) : 8'd0);
      bits[i] = en[i] & lb[b];
    end
    return bits;
  endfunction

  // Comma bit b on every enabled lane; commas are never offset.
  function automatic logic [LANES-1:0] comma_bits(input logic [2:0] b, input logic [LANES-1:0] en);
    return en & {LANES{COMMA[b]}};
  endfunction

  assign gen_next = next_byte(mode_l, gen_byte);

  // Frame sequencer: counters, generator state and registered outputs.
  always_ff @(posedge clk32) begin
    if (reset) begin
      state    <= IDLE;
      serial_o <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_sync  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          serial_o <= '0;
          busy     <= 1'b0;
          done     <= 1'b0;
          in_sync  <= 1'b0;
          if (start) begin
            mode_l   <= mode;
            offset_l <= lane_offset;
            en_l     <= lane_en;
            gen_byte <= (mode == 2'b10 && seed == 8'h00) ? 8'h01 : seed;
            bit_cnt  <= 3'd7;
            byte_cnt <= '0;
            serial_o <= comma_bits(3'd7, lane_en);
            busy     <= 1'b1;
            in_sync  <= 1'b1;
            state    <= SYNC;
          end
        end
        SYNC: begin
          if (bit_cnt != 3'd0) begin
            bit_cnt  <= bit_cnt - 3'd1;
            serial_o <= comma_bits(bit_cnt - 3'd1, en_l);
          end else if (byte_cnt != LAST_COMMA) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            bit_cnt  <= 3'd7;
            serial_o <= comma_bits(3'd7, en_l);
          end else begin
            byte_cnt <= '0;
            bit_cnt  <= 3'd7;
            in_sync  <= 1'b0;
            serial_o <= lane_bits(gen_byte, 3'd7, offset_l, en_l);
            state    <= DATA;
          end
        end
        DATA: begin
          if (bit_cnt != 3'd0) begin
            bit_cnt  <= bit_cnt - 3'd1;
            serial_o <= lane_bits(gen_byte, bit_cnt - 3'd1, offset_l, en_l);
            // Last payload bit goes out now; the next edge closes the frame.
            if (bit_cnt == 3'd1 && byte_cnt == LAST_PAY) state <= FIN;
          end else begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            bit_cnt  <= 3'd7;
            gen_byte <= gen_next;
            serial_o <= lane_bits(gen_next, 3'd7, offset_l, en_l);
          end
        end
        FIN: begin
          serial_o <= '0;
          busy     <= 1'b0;
          done     <= 1'b1;
          in_sync  <= 1'b0;
          byte_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_rx_pattern_gen.sv
// Directed scoreboard bench for phy_rx_pattern_gen (4 lanes, default framing).
module tb_phy_rx_pattern_gen;

  localparam int         LANES = 4;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         NC    = 4;
  localparam int         PB    = 4;

  typedef struct packed {
    logic [LANES-1:0] ser;
    logic             busy;
    logic             done;
    logic             sync;
  } exp_t;

  logic             clk32 = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       mode;
  logic [7:0]       seed;
  logic             lane_offset;
  logic [LANES-1:0] lane_en;
  logic [LANES-1:0] serial_o;
  logic             busy;
  logic             done;
  logic             in_sync;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clk32 = ~clk32;

  phy_rx_pattern_gen #(
    .LANES(LANES), .COMMA(COMMA), .NUM_COMMA(NC), .PAYLOAD_BYTES(PB), .CNT_W(8)
  ) dut (
    .clk32(clk32), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .lane_offset(lane_offset), .lane_en(lane_en), .serial_o(serial_o),
    .busy(busy), .done(done), .in_sync(in_sync)
  );

  function automatic logic [7:0] model_next(input logic [1:0] m, input logic [7:0] g);
    logic fb;
    fb = g[7] ^ g[5] ^ g[4] ^ g[3];
    if (m == 2'b01) return g + 8'd1;
    if (m == 2'b10) return (g << 1) | {7'd0, fb};
    return g;
  endfunction

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) q.push_back('0);
  endtask

  // Expected per-cycle outputs of one frame, starting at the start-sampling edge.
  task automatic push_frame(input logic [1:0] m, input logic [7:0] s, input logic off,
                            input logic [LANES-1:0] en);
    logic [7:0] g;
    logic [7:0] lb;
    exp_t       e;
    g = (m == 2'b10 && s == 8'h00) ? 8'h01 : s;
    for (int b = 0; b < NC; b++)
      for (int bit_i = 7; bit_i >= 0; bit_i--) begin
        e.ser  = COMMA[bit_i] ? en : '0;
        e.busy = 1'b1; e.done = 1'b0; e.sync = 1'b1;
        q.push_back(e);
      end
    for (int b = 0; b < PB; b++) begin
      for (int bit_i = 7; bit_i >= 0; bit_i--) begin
        for (int l = 0; l < LANES; l++) begin
          lb = off ? g + 8'(l) : g;
          e.ser[l] = en[l] ? lb[bit_i] : 1'b0;
        end
        e.busy = 1'b1; e.done = 1'b0; e.sync = 1'b0;
        q.push_back(e);
      end
      g = model_next(m, g);
    end
    e = '0; e.done = 1'b1;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs={ser,busy,done,sync}=%b required=%b", tag, obs, exp);
  endtask

  // Advance n edges; after each, compare outputs against the next scoreboard entry.
  task automatic run(input int n, input string tag);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk32);
      #1;
      e = (q.size() > 0) ? q.pop_front() : exp_t'('0);
      chk(tag, {serial_o, busy, done, in_sync}, e);
    end
  endtask

  task automatic frame(input logic [1:0] m, input logic [7:0] s, input logic off,
                       input logic [LANES-1:0] en, input string tag);
    mode = m; seed = s; lane_offset = off; lane_en = en; start = 1'b1;
    push_frame(m, s, off, en);
    push_idle(2);
    run(1, tag);
    start = 1'b0;
    run(66, tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; seed = 8'h00; lane_offset = 1'b0; lane_en = '0;
    push_idle(2);
    run(2, "reset_state");
    reset = 1'b0;
    push_idle(2);
    run(2, "idle");

    frame(2'b00, 8'hFF, 1'b0, 4'b0011, "fixed_ff");
    frame(2'b01, 8'hFE, 1'b0, 4'b1111, "incr_wrap");
    frame(2'b10, 8'h01, 1'b0, 4'b1111, "lfsr_01");
    frame(2'b10, 8'h00, 1'b0, 4'b1111, "lfsr_zero_seed");
    frame(2'b11, 8'h5A, 1'b0, 4'b0101, "mode11_fixed");
    frame(2'b00, 8'hEE, 1'b1, 4'b1011, "offset_en1011");
    frame(2'b01, 8'hFE, 1'b1, 4'b1111, "offset_incr_wrap");

    // Reset in the middle of a frame: abandoned with no done pulse.
    mode = 2'b01; seed = 8'h30; lane_offset = 1'b0; lane_en = 4'b1111; start = 1'b1;
    push_frame(2'b01, 8'h30, 1'b0, 4'b1111);
    run(1, "pre_reset");
    start = 1'b0;
    run(20, "pre_reset");
    reset = 1'b1;
    start = 1'b1;
    q.delete();
    push_idle(1);
    run(1, "mid_reset");
    reset = 1'b0;
    start = 1'b0;
    push_idle(4);
    run(4, "post_reset_no_done");
    frame(2'b01, 8'h30, 1'b0, 4'b1111, "after_reset");

    // Start held: back-to-back frames; seed change mid-frame hits only the next one.
    mode = 2'b01; seed = 8'h10; lane_offset = 1'b0; lane_en = 4'b1111; start = 1'b1;
    push_frame(2'b01, 8'h10, 1'b0, 4'b1111);
    push_frame(2'b01, 8'hA0, 1'b0, 4'b1111);
    push_idle(3);
    run(20, "b2b_frame1");
    seed = 8'hA0;
    run(50, "b2b_frame2");
    start = 1'b0;
    run(64, "b2b_tail");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
